// File: rtl/ce_pkg.sv
// Shared types and constants for the CE-to-clock bridge.
package ce_pkg;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        ACKED = 2'd2
    } ce_state_t;

    // Reset level of the Send_in synchroniser: Send_in is active-low, so
    // 1 means "no token present".
    localparam logic SYNC_RST = 1'b1;

endpackage

// File: rtl/ce_fifo.sv
// Small FIFO with a registered, first-word-through head register.
module ce_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              CLK,
    input  logic              MR_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_head;

    logic              w_do_push;
    logic              w_do_pop;
    logic [AW-1:0]     w_rd_next;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_head;

    // Pop at empty is ignored; a push at full is only taken alongside a pop.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_rd_next = r_rd_ptr + AW'(1);

    // Storage array: written on push, no reset so it maps onto RAM.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and the head register that feeds o_data.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);

            // The head always mirrors the entry at the read pointer. When the
            // next entry is not yet in the array it is the word being pushed.
            if (w_do_pop) begin
                if (r_count >= CW'(2)) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_do_push) begin
                    r_head <= i_data;
                end
            end else if (w_do_push && o_empty) begin
                r_head <= i_data;
            end
        end
    end

endmodule

// File: rtl/ce_sync_bridge.sv
// Bridge from a self-timed CE stage (4-phase, active-low Send/Ack) into the
// CLK domain, buffering tokens in a FIFO behind a valid/ready port.
module ce_sync_bridge
    import ce_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     MR_n,
    input  logic                     Send_in,
    input  logic [DATA_W-1:0]        Data_in,
    output logic                     Ack_out,
    output logic                     Out_valid,
    input  logic                     Out_ready,
    output logic [DATA_W-1:0]        Out_data,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    ce_state_t              r_state;
    logic                   r_ack;

    logic                   w_s_send;
    logic                   w_armed;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;

    assign w_s_send = r_sync[SYNC_STAGES-1];
    // The synchroniser's reset value is not a real observation of Send_in.
    // ARM only trusts s_send once the chain has been refilled from the pin,
    // so a token held low across reset can never look like a fresh one.
    assign w_armed  = r_fill[SYNC_STAGES-1];

    // Send_in synchroniser plus a parallel marker showing the chain is refilled.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            r_sync <= {SYNC_STAGES{SYNC_RST}};
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], Send_in};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Data_in is sampled only here, while the synchronised request is low.
    assign w_push = (r_state == IDLE) && !w_s_send && !w_full;

    // Handshake FSM with a registered Ack_out.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            r_state <= ARM;
            r_ack   <= 1'b1;
        end else begin
            case (r_state)
                ARM: begin
                    r_ack <= 1'b1;
                    if (w_armed && w_s_send) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    // When full, Ack is withheld; that is the backpressure.
                    if (w_push) begin
                        r_state <= ACKED;
                        r_ack   <= 1'b0;
                    end
                end
                ACKED: begin
                    if (w_s_send) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ARM;
                    r_ack   <= 1'b1;
                end
            endcase
        end
    end

    ce_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .MR_n    (MR_n),
        .i_push  (w_push),
        .i_data  (Data_in),
        .i_pop   (Out_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_data  (Out_data)
    );

    assign Ack_out   = r_ack;
    assign Out_valid = !w_empty;
    assign Count     = w_count;

endmodule

// File: tb/tb_ce_sync_bridge.sv
// Testbench for ce_sync_bridge: directed handshake/latency/backpressure/reset
// cases followed by a randomised run, checked by a queue scoreboard.
`timescale 1ns/1ps
module tb_ce_sync_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic          clk = 1'b0;
    logic          MR_n;
    logic          Send_in;
    logic [DW-1:0] Data_in;
    logic          Ack_out;
    logic          Out_valid;
    logic          Out_ready;
    logic [DW-1:0] Out_data;
    logic [2:0]    Count;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_pop    = 0;
    int            n_enq    = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    int            ready_mode = 0;   // 0: follow ready_val, 1: random each cycle
    logic          ready_val  = 1'b0;

    always #5 clk = ~clk;

    ce_sync_bridge #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .CLK       (clk),
        .MR_n      (MR_n),
        .Send_in   (Send_in),
        .Data_in   (Data_in),
        .Ack_out   (Ack_out),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_data  (Out_data),
        .Count     (Count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Advance n edges, landing 2 ns after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Bounded wait for Ack_out to reach a level; expiry is a failed check.
    task automatic wait_ack(input logic v, input int budget_ns, input string name);
        int t = 0;
        while (Ack_out !== v && t < budget_ns) begin
            #1;
            t++;
        end
        chk(name, 32'(Ack_out), 32'(v));
    endtask

    // Upstream presents a token: data first, then the active-low request.
    task automatic drop(input logic [DW-1:0] d);
        Data_in = d;
        Send_in = 1'b0;
        exp_q.push_back(d);
        n_enq++;
        $display("send %0d data=%h", n_enq, d);
    endtask

    task automatic pulse_ready();
        ready_val = 1'b1;
        cyc(1);
        ready_val = 1'b0;
    endtask

    function automatic int pick_d();
        int d = int'($urandom_range(3, 29));
        if (d % 10 == 5) d++;
        return d;
    endfunction

    // Consumer side: Out_ready changes 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) Out_ready = 1'($urandom_range(0, 1));
        else                 Out_ready = ready_val;
    end

    // Scoreboard monitor: every accepted head must be the oldest token sent.
    always @(negedge clk) begin
        if (MR_n === 1'b1 && Out_valid === 1'b1 && Out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %h required no token", Out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                n_pop++;
                if (Out_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %h required %h", Out_data, mon_exp);
                end else begin
                    $display("pop %0d data=%h", n_pop, Out_data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        MR_n      = 1'b0;
        Send_in   = 1'b0;
        Data_in   = 32'hDEAD_BEEF;
        Out_ready = 1'b0;

        // Reset with a token held low across it.
        cyc(3);
        chk("rst_ack", 32'(Ack_out), 32'd1);
        chk("rst_valid", 32'(Out_valid), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_data", Out_data, 32'd0);
        MR_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("held_token_ack", 32'(Ack_out), 32'd1);
        end
        chk("held_token_count", 32'(Count), 32'd0);
        Send_in = 1'b1;
        cyc(6);
        drop(32'h0000_00A5);
        wait_ack(1'b0, 200, "a5_ack_low");
        cyc(1);
        chk("a5_count", 32'(Count), 32'd1);
        Send_in = 1'b1;
        wait_ack(1'b1, 200, "a5_ack_high");
        cyc(1);
        pulse_ready();
        cyc(3);
        chk("a5_drained", 32'(Count), 32'd0);

        // Single token: exact SYNC_STAGES+1 edge latency in both directions.
        drop(32'h0000_1234);
        cyc(SS);
        chk("lat_fall_early", 32'(Ack_out), 32'd1);
        cyc(1);
        chk("lat_fall", 32'(Ack_out), 32'd0);
        chk("single_valid", 32'(Out_valid), 32'd1);
        chk("single_data", Out_data, 32'h0000_1234);
        chk("single_count", 32'(Count), 32'd1);
        Send_in = 1'b1;
        Data_in = 32'h5555_5555;
        cyc(SS);
        chk("lat_rise_early", 32'(Ack_out), 32'd0);
        cyc(1);
        chk("lat_rise", 32'(Ack_out), 32'd1);
        chk("single_count_hold", 32'(Count), 32'd1);
        pulse_ready();
        cyc(3);
        chk("single_drained", 32'(Count), 32'd0);

        // Backpressure: four tokens fill the FIFO, the fifth is held off.
        for (int i = 1; i <= 4; i++) begin
            drop(32'h100 + 32'(i));
            wait_ack(1'b0, 200, "bp_ack_low");
            Send_in = 1'b1;
            wait_ack(1'b1, 200, "bp_ack_high");
        end
        cyc(1);
        chk("bp_full_count", 32'(Count), 32'd4);
        drop(32'h105);
        cyc(12);
        chk("bp_ack_held", 32'(Ack_out), 32'd1);
        chk("bp_count_held", 32'(Count), 32'd4);
        pulse_ready();
        wait_ack(1'b0, 200, "bp_fifth_acked");
        cyc(1);
        chk("bp_count_refill", 32'(Count), 32'd4);
        Send_in = 1'b1;
        wait_ack(1'b1, 200, "bp_fifth_release");
        cyc(1);

        // Streaming with Out_ready held high while the FIFO drains and refills.
        ready_val = 1'b1;
        for (int i = 6; i <= 15; i++) begin
            drop(32'h100 + 32'(i));
            wait_ack(1'b0, 300, "stream_ack_low");
            chk("stream_count_le_depth", 32'(Count <= 3'(DEPTH)), 32'd1);
            Send_in = 1'b1;
            wait_ack(1'b1, 300, "stream_ack_high");
        end
        cyc(6);
        chk("stream_drained", 32'(Count), 32'd0);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);
        ready_val = 1'b0;
        cyc(2);

        // Reset in the middle of a handshake.
        drop(32'h0000_0BAD);
        wait_ack(1'b0, 200, "mid_ack_low");
        cyc(1);
        chk("mid_pre_count", 32'(Count), 32'd1);
        #1;
        MR_n = 1'b0;
        #1;
        chk("mid_async_ack", 32'(Ack_out), 32'd1);
        chk("mid_async_valid", 32'(Out_valid), 32'd0);
        chk("mid_async_count", 32'(Count), 32'd0);
        n_enq -= exp_q.size();
        exp_q.delete();
        cyc(3);
        MR_n = 1'b1;
        cyc(20);
        chk("mid_no_stale_ack", 32'(Ack_out), 32'd1);
        chk("mid_no_stale_count", 32'(Count), 32'd0);
        chk("mid_no_stale_valid", 32'(Out_valid), 32'd0);
        Send_in = 1'b1;
        cyc(6);

        // Randomised run with jittered upstream timing and random Out_ready.
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #(pick_d());
            drop($urandom());
            wait_ack(1'b0, 5000, "rnd_ack_low");
            @(negedge clk);
            #(pick_d());
            Send_in = 1'b1;
            Data_in = $urandom();
            wait_ack(1'b1, 5000, "rnd_ack_high");
        end
        ready_mode = 0;
        ready_val  = 1'b1;
        cyc(20);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("final_pop_total", 32'(n_pop), 32'(n_enq));
        chk("final_count", 32'(Count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
